// File: rtl/branch_redirect_unit.sv
// Fetch PC owner and branch prediction tracker (D -> E -> M); redirects fetch on M-stage mispredicts.
// Optional performance counters are enabled by defining BRU_PERF_CNT_EN.
module branch_redirect_unit #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            stallD,
    input  logic            stallE,
    input  logic            stallM,
    input  logic            branchD,
    input  logic            pred_takeD,
    input  logic [PC_W-1:0] pcD,
    input  logic [PC_W-1:0] branch_targetD,
    input  logic            actual_takeM,
    output logic [PC_W-1:0] pcF,
    output logic            flushD,
    output logic            flushE,
    output logic            flushM,
    output logic            branchM,
    output logic [PC_W-1:0] pcM,
`ifdef BRU_PERF_CNT_EN
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispredict_cnt,
`endif
    output logic            mispredictM
);

    typedef struct packed {
        logic            branch;
        logic            pred_take;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
        logic [PC_W-1:0] fallthrough;
    } stage_t;

    logic [PC_W-1:0] pc_f_q, pc_f_d;
    stage_t          stage_e_q, stage_e_d;
    stage_t          stage_m_q, stage_m_d;
    logic            mispredict_m;
    logic            pred_d_redirect;
    logic [PC_W-1:0] redirect_addr;

    // A resolved mispredict in M outranks a predicted-taken redirect from D.
    always_comb begin
        mispredict_m    = stage_m_q.branch & ~stallM
                          & (stage_m_q.pred_take != actual_takeM);
        redirect_addr   = actual_takeM ? stage_m_q.target : stage_m_q.fallthrough;
        pred_d_redirect = pred_takeD & branchD & ~stallD & ~mispredict_m;

        pc_f_d = pc_f_q + PC_W'(4);
        if (mispredict_m) begin
            pc_f_d = redirect_addr;
        end else if (pred_d_redirect) begin
            pc_f_d = branch_targetD;
        end else if (stallF) begin
            pc_f_d = pc_f_q;
        end

        stage_e_d = stage_e_q;
        if (mispredict_m || stallD) begin
            if (mispredict_m || !stallE) begin
                stage_e_d = '0;
            end
        end else if (!stallE) begin
            stage_e_d.branch      = branchD;
            stage_e_d.pred_take   = pred_takeD;
            stage_e_d.pc          = pcD;
            stage_e_d.target      = branch_targetD;
            stage_e_d.fallthrough = pcD + PC_W'(4);
        end

        stage_m_d = stage_m_q;
        if (mispredict_m) begin
            stage_m_d = '0;
        end else if (!stallM) begin
            stage_m_d = stallE ? '0 : stage_e_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_q    <= RESET_PC;
            stage_e_q <= '0;
            stage_m_q <= '0;
        end else begin
            pc_f_q    <= pc_f_d;
            stage_e_q <= stage_e_d;
            stage_m_q <= stage_m_d;
        end
    end

    assign pcF         = pc_f_q;
    assign flushD      = mispredict_m | pred_d_redirect;
    assign flushE      = mispredict_m;
    assign flushM      = mispredict_m;
    assign branchM     = stage_m_q.branch;
    assign pcM         = stage_m_q.pc;
    assign mispredictM = mispredict_m;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

    // A branch is counted once, on the cycle it leaves a non-stalled M stage.
    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (stage_m_q.branch && !stallM) begin
            branch_cnt_d = branch_cnt_q + 32'd1;
        end
        if (mispredict_m) begin
            mispredict_cnt_d = mispredict_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;
`endif

endmodule
